seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYC, default 4, consecutive identical synchronized samples required before capture (legal range 2-255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 seg_in  input  7  scanned segment bus, abcdefg order (bit6=a ... bit0=g), 1 = segment lit.
REQ-005 an_in  input  4  scanned digit select, active-high, one-hot when a digit is driven.
REQ-006 bcd_out  output  16  frame digits, digit n in bits [4n+3:4n].
REQ-007 err_out  output  4  per-digit flag: captured pattern not a legal 0-9 code.
REQ-008 frame_valid  output  1  complete frame present on bcd_out/err_out.
REQ-009 frame_ready  input  1  consumer accepts frame when high with frame_valid.
REQ-010 overrun  output  1  sticky: a complete frame was dropped while one was pending.

Function
REQ-011 seg_in and an_in SHALL each pass through a 2-flop synchronizer; all logic below uses synchronized values.
REQ-012 Pattern table SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-013 Any other pattern SHALL decode to digit 4'hF with the digit's err bit set.
REQ-014 FSM states SHALL be IDLE, SETTLE, HOLD.
REQ-015 IDLE: an_in not one-hot (zero or multiple bits) -> stay; one-hot -> SETTLE, stability counter = 1.
REQ-016 SETTLE: sample equals previous {an,seg} -> counter+1; differs -> counter = 1 (stay SETTLE if one-hot, else IDLE).
REQ-017 SETTLE: counter reaching STABLE_CYC SHALL capture decoded digit and err bit into working slot selected by an_in, set that slot's seen bit, go to HOLD.
REQ-018 HOLD: no further capture until {an,seg} changes; change -> SETTLE (one-hot) or IDLE (not one-hot).
REQ-019 Capture latency: STABLE_CYC cycles after the synchronized sample first appears, i.e. STABLE_CYC+2 clocks from input pins.
REQ-020 Recapture of an already-seen slot before frame completion SHALL overwrite that slot (latest value wins).
REQ-021 When all 4 seen bits are set, the working slots SHALL transfer to the output register on the next clock and seen bits clear to 0.
REQ-022 Transfer with frame_valid=0, or with frame_valid=1 and frame_ready=1 in the same cycle, SHALL load bcd_out/err_out and assert frame_valid.
REQ-023 Transfer with frame_valid=1 and frame_ready=0 SHALL discard the new frame, keep outputs unchanged, set overrun.
REQ-024 frame_valid SHALL deassert the cycle after frame_valid&frame_ready with no simultaneous transfer; bcd_out/err_out SHALL stay stable while frame_valid=1.
REQ-025 overrun SHALL clear only on reset.
REQ-026 Stability counter SHALL saturate at STABLE_CYC; never wraps.

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, counter 0, synchronizers 0, seen bits 0, working slots 0.
REQ-028 Reset outputs: bcd_out=16'h0000, err_out=4'h0, frame_valid=0, overrun=0.
REQ-029 Reset mid-SETTLE or mid-frame SHALL discard partial data; first frame after release requires all 4 digits recaptured.

Verification
REQ-030 Scan an=0001..1000 with patterns for 1,2,3,4, each held 10 clks, frame_ready=1 -> bcd_out=16'h4321, err_out=0, frame_valid pulses 1 cycle.
REQ-031 Digit 2 shows 0000001 -> bcd_out[11:8]=4'hF, err_out=4'b0100.
REQ-032 seg_in toggling every 3 clks on an=0001 (STABLE_CYC=4) -> no capture, seen bits stay 0, no frame.
REQ-033 frame_ready=0, two complete frames 5678 then 9012 -> bcd_out holds 16'h8765, overrun=1; frame_ready=1 -> frame_valid drops next cycle, overrun stays 1.
REQ-034 an_in=0011 held 20 clks -> no capture; then an_in=0001 with 8 -> slot 0 captures 8 after 6 clks.
REQ-035 rst pulsed after 3 of 4 digits captured -> all outputs reset values; next frame needs 4 new captures.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - scanned 7-segment display decoder into 4-digit BCD frames
// Debounces each digit of the scan, decodes it and presents complete frames with ready/valid handshake.
module seg_scan_decoder #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] bcd_out,
    output logic [3:0]  err_out,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYC);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [6:0]  seg_s1, seg_s2;
    logic [3:0]  an_s1, an_s2;
    logic [10:0] prev;
    logic [10:0] sample;
    logic        one_hot;
    logic        changed;
    logic        capture;
    logic [1:0]  slot_idx;
    logic [4:0]  dec;
    logic [3:0]  seen;
    logic [3:0]  work_bcd [4];
    logic [3:0]  work_err;
    logic        transfer;

    function automatic logic [4:0] decode7(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = {1'b0, 4'd0};
            7'b0110000: r = {1'b0, 4'd1};
            7'b1101101: r = {1'b0, 4'd2};
            7'b1111001: r = {1'b0, 4'd3};
            7'b0110011: r = {1'b0, 4'd4};
            7'b1011011: r = {1'b0, 4'd5};
            7'b1011111: r = {1'b0, 4'd6};
            7'b1110000: r = {1'b0, 4'd7};
            7'b1111111: r = {1'b0, 4'd8};
            7'b1111011: r = {1'b0, 4'd9};
            default:    r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            an_s1  <= '0;
            an_s2  <= '0;
            prev   <= '0;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            an_s1  <= an_in;
            an_s2  <= an_s1;
            prev   <= sample;
        end
    end

    assign sample  = {an_s2, seg_s2};
    assign changed = (sample != prev);
    assign one_hot = (an_s2 != 4'b0000) && ((an_s2 & (an_s2 - 4'd1)) == 4'b0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = 8'd1;
                end
            end
            SETTLE: begin
                if (changed) begin
                    cnt_nxt   = 8'd1;
                    state_nxt = one_hot ? SETTLE : IDLE;
                end else if ({1'b0, cnt} + 9'd1 >= {1'b0, STABLE}) begin
                    cnt_nxt   = STABLE;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt   = cnt + 8'd1;
                end
            end
            HOLD: begin
                if (changed) begin
                    cnt_nxt   = 8'd1;
                    state_nxt = one_hot ? SETTLE : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Capture fires on the edge where the stable count reaches STABLE_CYC
    always_comb begin
        capture = 1'b0;
        if (state == SETTLE && !changed && ({1'b0, cnt} + 9'd1 >= {1'b0, STABLE}))
            capture = 1'b1;
    end

    always_comb begin
        slot_idx = 2'd0;
        case (an_s2)
            4'b0010: slot_idx = 2'd1;
            4'b0100: slot_idx = 2'd2;
            4'b1000: slot_idx = 2'd3;
            default: slot_idx = 2'd0;
        endcase
    end

    assign dec      = decode7(seg_s2);
    assign transfer = (seen == 4'hF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen     <= '0;
            work_err <= '0;
            for (int i = 0; i < 4; i++) work_bcd[i] <= '0;
        end else begin
            if (capture) begin
                work_bcd[slot_idx] <= dec[3:0];
                work_err[slot_idx] <= dec[4];
            end
            if (transfer)
                seen <= capture ? an_s2 : 4'b0000;
            else if (capture)
                seen <= seen | an_s2;
        end
    end

    // A frame that arrives while the previous one is still unaccepted is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_out     <= '0;
            err_out     <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (transfer) begin
                if (!frame_valid || frame_ready) begin
                    bcd_out     <= {work_bcd[3], work_bcd[2], work_bcd[1], work_bcd[0]};
                    err_out     <= work_err;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = '0;
    logic [3:0]  an_in = '0;
    logic [15:0] bcd_out;
    logic [3:0]  err_out;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        overrun;

    int passed = 0;
    int total = 0;
    int fv_cycles = 0;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                           S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                           S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111,
                           S9 = 7'b1111011, SBAD = 7'b0000001;

    seg_scan_decoder #(.STABLE_CYC(4)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
        .bcd_out(bcd_out), .err_out(err_out), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_valid) fv_cycles++;
    end

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in = an;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        an_in = '0;
        seg_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        total++; if (bcd_out !== 16'h0000) $display("FAIL reset_bcd: got %h want 0000", bcd_out); else passed++;
        total++; if (err_out !== 4'h0) $display("FAIL reset_err: got %b want 0000", err_out); else passed++;
        total++; if (frame_valid !== 1'b0) $display("FAIL reset_fv: got %b want 0", frame_valid); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_scan;
        do_reset();
        frame_ready = 1'b1;
        fv_cycles = 0;
        show(4'b0001, S1, 10); show(4'b0010, S2, 10); show(4'b0100, S3, 10); show(4'b1000, S4, 10);
        show(4'b0000, 7'h00, 5);
        total++; if (bcd_out !== 16'h4321) $display("FAIL scan_bcd: got %h want 4321", bcd_out); else passed++;
        total++; if (err_out !== 4'h0) $display("FAIL scan_err: got %b want 0000", err_out); else passed++;
        total++; if (frame_valid !== 1'b0) $display("FAIL scan_fv_drop: got %b want 0", frame_valid); else passed++;
        total++; if (fv_cycles !== 1) $display("FAIL scan_fv_pulse: got %0d cycles want 1", fv_cycles); else passed++;
        show(4'b0001, S9, 10); show(4'b0010, S0, 10); show(4'b0100, S1, 10); show(4'b1000, S2, 10);
        show(4'b0000, 7'h00, 5);
        total++; if (bcd_out !== 16'h2109) $display("FAIL b2b_bcd: got %h want 2109", bcd_out); else passed++;
        total++; if (fv_cycles !== 2) $display("FAIL b2b_fv_pulse: got %0d cycles want 2", fv_cycles); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun); else passed++;
    endtask

    task automatic test_error;
        do_reset();
        frame_ready = 1'b1;
        fv_cycles = 0;
        show(4'b0001, S1, 10); show(4'b0010, S2, 10); show(4'b0100, SBAD, 10); show(4'b1000, S4, 10);
        show(4'b0000, 7'h00, 5);
        total++; if (bcd_out !== 16'h4F21) $display("FAIL err_bcd: got %h want 4f21", bcd_out); else passed++;
        total++; if (err_out !== 4'b0100) $display("FAIL err_flags: got %b want 0100", err_out); else passed++;
        total++; if (fv_cycles !== 1) $display("FAIL err_fv_pulse: got %0d cycles want 1", fv_cycles); else passed++;
    endtask

    task automatic test_toggle;
        do_reset();
        frame_ready = 1'b1;
        fv_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            show(4'b0001, S1, 3);
            show(4'b0001, S7, 3);
        end
        show(4'b0010, S2, 10); show(4'b0100, S3, 10); show(4'b1000, S4, 10);
        show(4'b0000, 7'h00, 5);
        total++; if (fv_cycles !== 0) $display("FAIL toggle_no_frame: got %0d cycles want 0", fv_cycles); else passed++;
        show(4'b0001, S8, 10);
        show(4'b0000, 7'h00, 3);
        total++; if (fv_cycles !== 1) $display("FAIL toggle_fv_pulse: got %0d cycles want 1", fv_cycles); else passed++;
        total++; if (bcd_out !== 16'h4328) $display("FAIL toggle_bcd: got %h want 4328", bcd_out); else passed++;
    endtask

    task automatic test_overrun;
        do_reset();
        frame_ready = 1'b0;
        show(4'b0001, S5, 10); show(4'b0010, S6, 10); show(4'b0100, S7, 10); show(4'b1000, S8, 10);
        show(4'b0001, S9, 10); show(4'b0010, S0, 10); show(4'b0100, S1, 10); show(4'b1000, S2, 10);
        show(4'b0000, 7'h00, 3);
        total++; if (bcd_out !== 16'h8765) $display("FAIL ovr_bcd: got %h want 8765", bcd_out); else passed++;
        total++; if (err_out !== 4'h0) $display("FAIL ovr_err: got %b want 0000", err_out); else passed++;
        total++; if (frame_valid !== 1'b1) $display("FAIL ovr_fv: got %b want 1", frame_valid); else passed++;
        total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else passed++;
        frame_ready = 1'b1;
        @(negedge clk);
        total++; if (frame_valid !== 1'b0) $display("FAIL ovr_fv_drop: got %b want 0", frame_valid); else passed++;
        total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else passed++;
    endtask

    task automatic test_reset_mid;
        frame_ready = 1'b1;
        fv_cycles = 0;
        show(4'b0001, S1, 10); show(4'b0010, S2, 10); show(4'b0100, S3, 10);
        show(4'b0000, 7'h00, 2);
        rst = 1'b1;
        #1;
        total++; if (bcd_out !== 16'h0000) $display("FAIL mid_bcd: got %h want 0000", bcd_out); else passed++;
        total++; if (err_out !== 4'h0) $display("FAIL mid_err: got %b want 0000", err_out); else passed++;
        total++; if (frame_valid !== 1'b0) $display("FAIL mid_fv: got %b want 0", frame_valid); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL mid_overrun: got %b want 0", overrun); else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        show(4'b1000, S4, 10);
        show(4'b0000, 7'h00, 3);
        total++; if (fv_cycles !== 0) $display("FAIL mid_partial_lost: got %0d cycles want 0", fv_cycles); else passed++;
        show(4'b0001, S1, 10); show(4'b0010, S2, 10); show(4'b0100, S3, 10);
        show(4'b0000, 7'h00, 3);
        total++; if (fv_cycles !== 1) $display("FAIL mid_refill_pulse: got %0d cycles want 1", fv_cycles); else passed++;
        total++; if (bcd_out !== 16'h4321) $display("FAIL mid_refill_bcd: got %h want 4321", bcd_out); else passed++;
    endtask

    task automatic test_multihot;
        do_reset();
        frame_ready = 1'b1;
        fv_cycles = 0;
        show(4'b0010, S1, 10); show(4'b0100, S2, 10); show(4'b1000, S3, 10);
        show(4'b0011, S8, 20);
        total++; if (fv_cycles !== 0) $display("FAIL multihot_no_capture: got %0d cycles want 0", fv_cycles); else passed++;
        show(4'b0001, S8, 6);
        total++; if (frame_valid !== 1'b0) $display("FAIL latency_early: got %b want 0", frame_valid); else passed++;
        @(negedge clk);
        total++; if (frame_valid !== 1'b1) $display("FAIL latency_frame: got %b want 1", frame_valid); else passed++;
        total++; if (bcd_out !== 16'h3218) $display("FAIL multihot_bcd: got %h want 3218", bcd_out); else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_scan();
        test_error();
        test_toggle();
        test_overrun();
        test_reset_mid();
        test_multihot();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
